mbfifo: RTL

//  Single-clock, N-buffer packet FIFO; next generation of the ping-pong FIFO.

---
 rtl/mbfifo_pkg.sv | 27 ++
 rtl/mbfifo_ram.sv | 32 +++
 rtl/mbfifo.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mbfifo_pkg.sv
// Shared definitions for the multi-buffer packet FIFO.
//   buf_state_e : lifecycle of one packet buffer
//   rd_state_e  : reader side (idle / buffer presented / buffer draining)
//   clog2       : ceiling log2, used to size index and counter fields
package mbfifo_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY    = 2'd0,
    BUF_FILLING  = 2'd1,
    BUF_FULL     = 2'd2,
    BUF_DRAINING = 2'd3
  } buf_state_e;

  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_PRESENT = 2'd1,
    RD_DRAIN   = 2'd2
  } rd_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/mbfifo_ram.sv
// Simple dual-port RAM backing all packet buffers.
//   clk, rst_n     : clock, async active-low reset (clears only the read register)
//   we/waddr/wdata : write port
//   re/raddr/rdata : registered read port; rdata holds its value while re is low
module mbfifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int WORDS      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register is reset so no word from before a reset can appear on rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mbfifo.sv
// Single-clock N-buffer packet FIFO. The writer claims an empty buffer, fills it
// and commits it; committed buffers are presented to the reader in commit order
// with first-word-fall-through read data.
//   write_ready/write_activate/write_strobe/write_data : writer side
//   write_fifo_size : words per buffer
//   read_ready/read_activate/read_strobe/read_data/read_count : reader side
//   starved, overflow, underflow : status / error pulses
//
// state        | meaning
// BUF_EMPTY    | free, may be claimed by the writer
// BUF_FILLING  | claimed, accepting writes
// BUF_FULL     | committed, waiting in the order queue or presented
// BUF_DRAINING | claimed by the reader
// RD_IDLE      | nothing presented
// RD_PRESENT   | queue head popped, read_ready high
// RD_DRAIN     | reader owns the buffer
module mbfifo
  import mbfifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int NUM_BUFFERS   = 2,
  parameter int COUNT_WIDTH   = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [NUM_BUFFERS-1:0] write_ready,
  input  logic [NUM_BUFFERS-1:0] write_activate,
  output logic [COUNT_WIDTH-1:0] write_fifo_size,
  input  logic                   write_strobe,
  input  logic [DATA_WIDTH-1:0]  write_data,
  output logic                   starved,
  output logic                   overflow,
  output logic                   read_ready,
  input  logic                   read_activate,
  output logic [COUNT_WIDTH-1:0] read_count,
  input  logic                   read_strobe,
  output logic [DATA_WIDTH-1:0]  read_data,
  output logic                   underflow
);

  localparam int DEPTH  = 1 << ADDRESS_WIDTH;
  localparam int IDX_W  = clog2(NUM_BUFFERS);
  localparam int CW     = ADDRESS_WIDTH + 1;
  localparam int QW     = clog2(NUM_BUFFERS + 1);
  localparam int RAM_AW = IDX_W + ADDRESS_WIDTH;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  buf_state_e             st_q [NUM_BUFFERS];
  buf_state_e             st_d [NUM_BUFFERS];
  logic [CW-1:0]          wcount_q [NUM_BUFFERS];
  logic [NUM_BUFFERS-1:0] wa_q;
  logic                   rst_done_q, wr_busy_q, ovf_q, unf_q;
  logic [IDX_W-1:0]       widx_q, ridx_q, claim_idx;
  logic [IDX_W-1:0]       q_mem [NUM_BUFFERS];
  logic [IDX_W-1:0]       q_head_q, q_tail_q;
  logic [QW-1:0]          q_cnt_q;
  rd_state_e              rd_q, rd_d;
  logic [CW-1:0]          rptr_q, rptr_d, rcount;
  logic                   claim, commit, commit_full, fill_active, wr_ok;
  logic                   rd_act, rd_rel, rd_ok, pop, ram_re;
  logic [ADDRESS_WIDTH-1:0] rd_off;
  logic [RAM_AW-1:0]      ram_waddr, ram_raddr;

  function automatic logic [IDX_W-1:0] q_next(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(NUM_BUFFERS - 1)) ? '0 : p + IDX_W'(1);
  endfunction

  // Only one buffer fills at a time; among rising claims the lowest empty one wins.
  always_comb begin
    claim     = 1'b0;
    claim_idx = '0;
    for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
      if (write_activate[i] && !wa_q[i] && st_q[i] == BUF_EMPTY && !wr_busy_q && rst_done_q) begin
        claim     = 1'b1;
        claim_idx = IDX_W'(i);
      end
    end
  end

  assign fill_active = wr_busy_q && write_activate[widx_q];
  assign commit      = wr_busy_q && !write_activate[widx_q];
  assign commit_full = commit && (wcount_q[widx_q] != '0);
  assign wr_ok       = write_strobe && fill_active && (wcount_q[widx_q] != FULL_COUNT);

  assign rcount = wcount_q[ridx_q];
  assign rd_act = (rd_q == RD_PRESENT) && read_activate;
  assign rd_rel = (rd_q == RD_DRAIN) && !read_activate;
  assign rd_ok  = (rd_q == RD_DRAIN) && read_activate && read_strobe && (rptr_q != rcount);
  // A release frees the reader in the same cycle, so the next head can be popped at once.
  // Pop never sees a same-cycle push, which keeps the bypass at two cycles.
  assign pop    = ((rd_q == RD_IDLE) || rd_rel) && (q_cnt_q != '0);
  assign rptr_d = rptr_q + CW'(rd_ok);

  // Look ahead by one word so read_data advances on every accepted strobe.
  assign rd_off    = (rd_q == RD_DRAIN) ? rptr_d[ADDRESS_WIDTH-1:0] : '0;
  assign ram_re    = rd_act || rd_ok;
  assign ram_waddr = {widx_q, wcount_q[widx_q][ADDRESS_WIDTH-1:0]};
  assign ram_raddr = {ridx_q, rd_off};

  always_comb begin
    st_d = st_q;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      if (claim && claim_idx == IDX_W'(i))  st_d[i] = BUF_FILLING;
      if (commit && widx_q == IDX_W'(i))    st_d[i] = commit_full ? BUF_FULL : BUF_EMPTY;
      if (rd_act && ridx_q == IDX_W'(i))    st_d[i] = BUF_DRAINING;
      if (rd_rel && ridx_q == IDX_W'(i))    st_d[i] = BUF_EMPTY;
    end
  end

  always_comb begin
    rd_d = rd_q;
    case (rd_q)
      RD_IDLE:    if (pop) rd_d = RD_PRESENT;
      RD_PRESENT: if (read_activate) rd_d = RD_DRAIN;
      RD_DRAIN:   if (!read_activate) rd_d = pop ? RD_PRESENT : RD_IDLE;
      default:    rd_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        st_q[i]     <= BUF_EMPTY;
        wcount_q[i] <= '0;
        q_mem[i]    <= '0;
      end
      wa_q       <= '0;
      rst_done_q <= 1'b0;
      wr_busy_q  <= 1'b0;
      widx_q     <= '0;
      q_head_q   <= '0;
      q_tail_q   <= '0;
      q_cnt_q    <= '0;
      rd_q       <= RD_IDLE;
      ridx_q     <= '0;
      rptr_q     <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      st_q       <= st_d;
      rd_q       <= rd_d;
      wa_q       <= write_activate;
      rst_done_q <= 1'b1;
      ovf_q      <= write_strobe && !wr_ok;
      unf_q      <= read_strobe && !rd_ok;
      if (claim) begin
        wr_busy_q           <= 1'b1;
        widx_q              <= claim_idx;
        wcount_q[claim_idx] <= '0;
      end else if (commit) begin
        wr_busy_q <= 1'b0;
      end
      if (wr_ok) wcount_q[widx_q] <= wcount_q[widx_q] + CW'(1);
      if (commit_full) begin
        q_mem[q_tail_q] <= widx_q;
        q_tail_q        <= q_next(q_tail_q);
      end
      if (pop) begin
        ridx_q   <= q_mem[q_head_q];
        q_head_q <= q_next(q_head_q);
      end
      if (commit_full && !pop)      q_cnt_q <= q_cnt_q + QW'(1);
      else if (pop && !commit_full) q_cnt_q <= q_cnt_q - QW'(1);
      rptr_q <= rd_act ? '0 : rptr_d;
    end
  end

  always_comb begin
    write_ready = '0;
    starved     = 1'b1;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      write_ready[i] = rst_done_q && (st_q[i] == BUF_EMPTY);
      if (st_q[i] == BUF_FULL || st_q[i] == BUF_DRAINING) starved = 1'b0;
    end
  end

  assign write_fifo_size = COUNT_WIDTH'(DEPTH);
  assign read_ready      = (rd_q == RD_PRESENT);
  assign read_count      = (rd_q != RD_IDLE) ? COUNT_WIDTH'(rcount) : '0;
  assign overflow        = ovf_q;
  assign underflow       = unf_q;

  mbfifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(RAM_AW),
    .WORDS     (NUM_BUFFERS * DEPTH)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wr_ok),
    .waddr(ram_waddr),
    .wdata(write_data),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(read_data)
  );

endmodule
